bus_write_sequencer: RTL and testbench

- Upstream master for the three-agent multi-drop data bus: accepts write commands (destination + byte) on a valid/ready port and buffers them in a small FIFO.
- Issues each command as a single-cycle bus write: drives the data bus and exactly the matching agent enable(s).
- Inserts a programmable bus-release (turnaround) gap between writes.
- Its outputs connect directly to the agent registers' Data_bus / A_EN / B_EN / C_EN inputs.

---
 rtl/bus_seq_pkg.sv | 30 +++
 rtl/bus_write_sequencer_if.sv | 25 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/bus_write_sequencer.sv | 114 +++++++++++
 tb/tb_bus_write_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_seq_pkg.sv
// Shared definitions for the multi-drop bus write sequencer.
// Contents: destination codes, FSM state encoding, and dest -> {C,B,A} enable decode.
// No ports; imported by the sequencer top.
package bus_seq_pkg;

  // Destination codes carried on cmd_dest
  localparam logic [1:0] DEST_A   = 2'd0;
  localparam logic [1:0] DEST_B   = 2'd1;
  localparam logic [1:0] DEST_C   = 2'd2;
  localparam logic [1:0] DEST_ALL = 2'd3;

  // FSM encoding kept as plain constants so legacy tools see a bit vector
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t DRIVE = 2'd1;
  localparam state_t TURN  = 2'd2;

  // Enable vector bit order is {C_EN, B_EN, A_EN}
  function automatic logic [2:0] dest_to_en(input logic [1:0] dest);
    logic [2:0] en;
    case (dest)
      DEST_A:  en = 3'b001;
      DEST_B:  en = 3'b010;
      DEST_C:  en = 3'b100;
      default: en = 3'b111;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/bus_write_sequencer_if.sv
// Command port plus agent-bus signals of the write sequencer.
// Signals: cmd_valid/cmd_ready/cmd_dest/cmd_data (command handshake), Data_bus/A_EN/B_EN/C_EN (bus).
// master = command source / bus observer, slave = the sequencer itself.
interface bus_write_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_dest;
  logic [DATA_W-1:0] cmd_data;
  logic [DATA_W-1:0] Data_bus;
  logic              A_EN;
  logic              B_EN;
  logic              C_EN;

  modport master (
    output cmd_valid, cmd_dest, cmd_data,
    input  cmd_ready, Data_bus, A_EN, B_EN, C_EN
  );

  modport slave (
    input  cmd_valid, cmd_dest, cmd_data,
    output cmd_ready, Data_bus, A_EN, B_EN, C_EN
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy count and first-word-fall-through head.
// Latency: a word pushed at edge k is visible on head during cycle k..k+1.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keeps level.
// Ports: clock, reset (sync, active-high), push/push_data, pop, head, full, empty, level.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; occupancy alone defines what is valid
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (do_pop && !do_push) level <= level - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/bus_write_sequencer.sv
// Buffers write commands and issues each as a one-cycle write on the shared agent bus.
// Latency: command pushed into an empty queue at edge k drives the bus in cycle k+1..k+2.
// Backpressure: cmd_ready = !full && !reset, independent of a same-cycle pop.
// Ports: clock, reset (sync, active-high), bus (slave: cmd handshake + Data_bus/A_EN/B_EN/C_EN),
//        busy, level, and xfer_cnt only when BUS_SEQ_XFER_CNT_EN is defined.
module bus_write_sequencer
  import bus_seq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  bus_write_sequencer_if.slave   bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
`ifdef BUS_SEQ_XFER_CNT_EN
  ,
  output logic [15:0]            xfer_cnt
`endif
);
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES + 1) : 1;
  localparam int FW = DATA_W + 2;

  state_t            state, state_nxt;
  logic [TW-1:0]     turn_cnt, turn_cnt_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic [2:0]        en_q, en_nxt;
  logic              push, pop, full, empty, can_issue;
  logic [FW-1:0]     head;
  logic [1:0]        head_dest;
  logic [DATA_W-1:0] head_data;

  assign {head_dest, head_data} = head;
  assign bus.cmd_ready = !full && !reset;
  assign push          = bus.cmd_valid && bus.cmd_ready;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({bus.cmd_dest, bus.cmd_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    data_nxt     = '0;
    en_nxt       = '0;
    pop          = 1'b0;
    // Edges at which a new write may start: from IDLE, from DRIVE only with
    // no turnaround, and on the last TURN cycle (which acts like IDLE)
    case (state)
      DRIVE:   can_issue = (TURN_CYCLES == 0);
      TURN:    can_issue = (turn_cnt <= TW'(1));
      default: can_issue = 1'b1;
    endcase
    if (can_issue && !empty) begin
      pop       = 1'b1;
      state_nxt = DRIVE;
      data_nxt  = head_data;
      en_nxt    = dest_to_en(head_dest);
    end else if (state == DRIVE && TURN_CYCLES > 0) begin
      state_nxt    = TURN;
      turn_cnt_nxt = TW'(TURN_CYCLES);
    end else if (state == TURN && !can_issue) begin
      turn_cnt_nxt = turn_cnt - TW'(1);
    end else begin
      state_nxt = IDLE;
    end
  end

  // Bus outputs are registered and cleared outside DRIVE, so enables can
  // only be high for the single cycle a command is loaded
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      turn_cnt <= '0;
      data_q   <= '0;
      en_q     <= '0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_cnt_nxt;
      data_q   <= data_nxt;
      en_q     <= en_nxt;
    end
  end

  assign bus.Data_bus = data_q;
  assign bus.A_EN     = en_q[0];
  assign bus.B_EN     = en_q[1];
  assign bus.C_EN     = en_q[2];
  assign busy         = (state != IDLE) || !empty;

`ifdef BUS_SEQ_XFER_CNT_EN
  // One count per DRIVE cycle that reaches its closing edge; broadcast is one write
  always_ff @(posedge clock) begin
    if (reset) begin
      xfer_cnt <= '0;
    end else if (state == DRIVE && xfer_cnt != 16'hFFFF) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bus_write_sequencer.sv
// Directed bench for bus_write_sequencer: four instances with TURN_CYCLES 0..3 share clock/reset.
// A negedge monitor logs every enable pulse per instance; checks compare the log to hand-computed cycles.
// Build with BUS_SEQ_XFER_CNT_EN defined to include the transfer-counter checks.
`timescale 1ns/1ps
module tb_bus_write_sequencer;
  import bus_seq_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic       valid [4];
  logic [1:0] dest  [4];
  logic [7:0] data  [4];
  logic       ready [4];
  logic [7:0] dbus  [4];
  logic [2:0] en    [4];
  logic       busy  [4];
  logic [2:0] level [4];
`ifdef BUS_SEQ_XFER_CNT_EN
  logic [15:0] xcnt [4];
`endif

  int checks    = 0;
  int failures  = 0;
  int stall_cnt = 0;

  int         log_n   [4] = '{default: 0};
  int         stray   [4] = '{default: 0};
  int         log_cyc [4][32];
  logic [2:0] log_en  [4][32];
  logic [7:0] log_dat [4][32];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bus_write_sequencer_if #(.DATA_W(8)) bif ();
    assign bif.cmd_valid = valid[g];
    assign bif.cmd_dest  = dest[g];
    assign bif.cmd_data  = data[g];
    assign ready[g]      = bif.cmd_ready;
    assign dbus[g]       = bif.Data_bus;
    assign en[g]         = {bif.C_EN, bif.B_EN, bif.A_EN};

    bus_write_sequencer #(
      .DATA_W      (8),
      .DEPTH       (4),
      .TURN_CYCLES (g)
    ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif),
      .busy  (busy[g]),
      .level (level[g])
`ifdef BUS_SEQ_XFER_CNT_EN
      ,
      .xfer_cnt (xcnt[g])
`endif
    );
  end

  // Record every cycle with any enable high; data on an idle bus is an error
  always @(negedge clock) begin
    for (int g = 0; g < 4; g++) begin
      if (en[g] != 3'b000) begin
        if (log_n[g] < 32) begin
          log_cyc[g][log_n[g]] = cyc;
          log_en[g][log_n[g]]  = en[g];
          log_dat[g][log_n[g]] = dbus[g];
        end
        log_n[g] = log_n[g] + 1;
      end else if (dbus[g] != 8'h00) begin
        stray[g] = stray[g] + 1;
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pulse(input int g, input int idx, input int exp_cyc,
                             input logic [2:0] exp_en, input logic [7:0] exp_dat);
    chk_eq("pulse_cycle", 32'(log_cyc[g][idx]), 32'(exp_cyc));
    chk_eq("pulse_en",    32'(log_en[g][idx]),  32'(exp_en));
    chk_eq("pulse_data",  32'(log_dat[g][idx]), 32'(exp_dat));
  endtask

  // Called just after an edge; holds valid until accepted, returns acceptance edge
  task automatic push_one(input int g, input logic [1:0] d, input logic [7:0] x, output int edge_k);
    int  n;
    logic r;
    n        = 0;
    edge_k   = -1;
    valid[g] = 1'b1;
    dest[g]  = d;
    data[g]  = x;
    while (edge_k < 0 && n < 50) begin
      r = ready[g];
      if (!r) begin
        stall_cnt++;
        chk_eq("stall_only_when_full", 32'(level[g]), 32'd4);
      end
      @(posedge clock);
      #1;
      if (r) edge_k = cyc;
      n++;
    end
    valid[g] = 1'b0;
    if (edge_k < 0) chk_eq("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k0, k1, k2, base;
    int ks [6];
    logic [2:0] en_tab [4];
    en_tab = '{3'b001, 3'b010, 3'b100, 3'b111};
    for (int g = 0; g < 4; g++) begin
      valid[g] = 1'b0;
      dest[g]  = 2'd0;
      data[g]  = 8'h00;
    end

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk_eq("rst_level", 32'(level[g]), 32'd0);
      chk_eq("rst_en",    32'(en[g]),    32'd0);
    end
    chk_eq("rst_data",  32'(dbus[1]),  32'd0);
    chk_eq("rst_busy",  32'(busy[1]),  32'd0);
    chk_eq("rst_ready", 32'(ready[1]), 32'd0);
    reset = 1'b0;
    #1;
    chk_eq("ready_after_rst", 32'(ready[1]), 32'd1);

    // Single write to B with one-cycle turnaround
    base = log_n[1];
    push_one(1, DEST_B, 8'hA5, k0);
    repeat (6) @(posedge clock);
    #1;
    chk_eq("single_count", log_n[1] - base, 32'd1);
    check_pulse(1, base, k0 + 1, 3'b010, 8'hA5);
    chk_eq("single_idle_busy", 32'(busy[1]), 32'd0);

    // Two-cycle turnaround between three queued writes
    base = log_n[2];
    push_one(2, DEST_A,   8'h11, k0);
    push_one(2, DEST_C,   8'h22, k1);
    push_one(2, DEST_ALL, 8'h33, k2);
    chk_eq("turn_push_b2b", k2 - k0, 32'd2);
    repeat (15) @(posedge clock);
    #1;
    chk_eq("turn_count", log_n[2] - base, 32'd3);
    check_pulse(2, base,     k0 + 1, 3'b001, 8'h11);
    check_pulse(2, base + 1, k0 + 4, 3'b100, 8'h22);
    check_pulse(2, base + 2, k0 + 7, 3'b111, 8'h33);

    // Back-to-back writes, no turnaround
    base = log_n[0];
    push_one(0, 2'd0, 8'h01, k0);
    push_one(0, 2'd1, 8'h02, k1);
    push_one(0, 2'd2, 8'h03, k1);
    push_one(0, 2'd3, 8'h04, k1);
    repeat (10) @(posedge clock);
    #1;
    chk_eq("b2b_count", log_n[0] - base, 32'd4);
    check_pulse(0, base,     k0 + 1, 3'b001, 8'h01);
    check_pulse(0, base + 1, k0 + 2, 3'b010, 8'h02);
    check_pulse(0, base + 2, k0 + 3, 3'b100, 8'h03);
    check_pulse(0, base + 3, k0 + 4, 3'b111, 8'h04);

    // Fill the queue against a slow drain (three-cycle turnaround)
    stall_cnt = 0;
    base = log_n[3];
    for (int i = 0; i < 6; i++) push_one(3, 2'(i), 8'(8'h60 + i), ks[i]);
    chk_eq("full_stalled", 32'(stall_cnt > 0), 32'd1);
    repeat (30) @(posedge clock);
    #1;
    chk_eq("full_count", log_n[3] - base, 32'd6);
    for (int i = 0; i < 6; i++)
      check_pulse(3, base + i, ks[0] + 1 + 4 * i, en_tab[i % 4], 8'(8'h60 + i));
    chk_eq("full_drained_level", 32'(level[3]), 32'd0);
    chk_eq("full_drained_busy",  32'(busy[3]),  32'd0);

    // Reset in the middle of a DRIVE cycle with a second command queued
    push_one(1, DEST_ALL, 8'h5A, k0);
    push_one(1, DEST_C,   8'h77, k1);
    chk_eq("pre_rst_drive", 32'(en[1]), 32'd7);
    reset = 1'b1;
    #1;
    chk_eq("mid_rst_ready", 32'(ready[1]), 32'd0);
    @(posedge clock);
    #1;
    base = log_n[1];
    chk_eq("mid_rst_en",    32'(en[1]),    32'd0);
    chk_eq("mid_rst_data",  32'(dbus[1]),  32'd0);
    chk_eq("mid_rst_level", 32'(level[1]), 32'd0);
    chk_eq("mid_rst_busy",  32'(busy[1]),  32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk_eq("post_rst_ready", 32'(ready[1]), 32'd1);
    repeat (6) @(posedge clock);
    #1;
    chk_eq("rst_discard", log_n[1] - base, 32'd0);
    chk_eq("post_rst_busy", 32'(busy[1]), 32'd0);

`ifdef BUS_SEQ_XFER_CNT_EN
    chk_eq("xfer_after_rst", 32'(xcnt[1]), 32'd0);
    push_one(1, DEST_A,   8'h81, k0);
    push_one(1, DEST_B,   8'h82, k0);
    push_one(1, DEST_ALL, 8'h83, k0);
    push_one(1, DEST_C,   8'h84, k0);
    push_one(1, DEST_A,   8'h85, k0);
    repeat (20) @(posedge clock);
    #1;
    chk_eq("xfer_cnt", 32'(xcnt[1]), 32'd5);
`endif

    for (int g = 0; g < 4; g++) chk_eq("stray_data", stray[g], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
